// File: rtl/uart_gen_pulse_pkg.sv
// Shared UART constants: system clock, line rate and the derived baud divisor
// used as the default period by uart_gen_pulse and uart_send.
package uart_gen_pulse_pkg;

  localparam int unsigned UART_CLK_FREQ   = 32'd100_000_000;
  localparam int unsigned UART_BAUD       = 32'd115_200;
  // Rounded to nearest: (F + B/2) / B
  localparam int unsigned UART_BAUD_DIV   = (UART_CLK_FREQ + (UART_BAUD / 32'd2)) / UART_BAUD;
  localparam int unsigned GEN_PULSE_WIDTH = 32'd10;

endpackage

// File: rtl/uart_gen_pulse_if.sv
// Output bundle of the baud tick generator: strobe, debug square wave and live count.
interface uart_gen_pulse_if #(
  parameter int unsigned WIDTH = 32'd10
);

  logic             pulse;
  logic             test;
  logic [WIDTH-1:0] counter;

  modport master (output pulse, output test, output counter);
  modport slave  (input  pulse, input  test, input  counter);

endinterface

// File: rtl/uart_gen_pulse.sv
// Baud tick generator: free-running modulo-DIVISOR counter with a registered
// one-cycle strobe at each wrap and a debug flop that toggles on every strobe.
module uart_gen_pulse
  import uart_gen_pulse_pkg::*;
#(
  parameter int unsigned DIVISOR = UART_BAUD_DIV,
  parameter int unsigned WIDTH   = GEN_PULSE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  uart_gen_pulse_if.master pulse_if
);

  if ((DIVISOR < 32'd2) || (64'(DIVISOR) > (64'd1 << WIDTH))) begin : g_bad_divisor
    $fatal(1, "uart_gen_pulse: DIVISOR must lie in 2 .. 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] TERM_COUNT = WIDTH'(DIVISOR - 32'd1);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             pulse_q, pulse_d;
  logic             test_q, test_d;

  // Next-state: wrap and strobe at terminal count, otherwise count up.
  always_comb begin
    counter_d = counter_q;
    pulse_d   = 1'b0;
    test_d    = test_q;
    if (counter_q == TERM_COUNT) begin
      counter_d = '0;
      pulse_d   = 1'b1;
      test_d    = ~test_q;
    end else begin
      counter_d = counter_q + WIDTH'(1'b1);
      pulse_d   = 1'b0;
      test_d    = test_q;
    end
  end

  // State flops; reset clears everything so a mid-period reset drops the partial period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter_q <= '0;
      pulse_q   <= 1'b0;
      test_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      pulse_q   <= pulse_d;
      test_q    <= test_d;
    end
  end

  assign pulse_if.counter = counter_q;
  assign pulse_if.pulse   = pulse_q;
  assign pulse_if.test    = test_q;

endmodule

// File: tb/tb_uart_gen_pulse.sv
// Directed bench for uart_gen_pulse at DIVISOR = 4, 2 and the 868 default.
module tb_uart_gen_pulse;

  logic clk;
  logic rst;

  int unsigned vec_cnt;
  int unsigned err_cnt;

  uart_gen_pulse_if #(.WIDTH(10)) if4   ();
  uart_gen_pulse_if #(.WIDTH(10)) if2   ();
  uart_gen_pulse_if #(.WIDTH(10)) ifdef ();

  uart_gen_pulse #(.DIVISOR(4), .WIDTH(10)) dut4 (.clk(clk), .rst(rst), .pulse_if(if4));
  uart_gen_pulse #(.DIVISOR(2), .WIDTH(10)) dut2 (.clk(clk), .rst(rst), .pulse_if(if2));
  uart_gen_pulse                            dutd (.clk(clk), .rst(rst), .pulse_if(ifdef));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_clear(input string tag);
    check_val({tag, " cnt4"},  32'(if4.counter),   32'd0);
    check_val({tag, " pul4"},  32'(if4.pulse),     32'd0);
    check_val({tag, " tst4"},  32'(if4.test),      32'd0);
    check_val({tag, " cnt2"},  32'(if2.counter),   32'd0);
    check_val({tag, " pul2"},  32'(if2.pulse),     32'd0);
    check_val({tag, " cntd"},  32'(ifdef.counter), 32'd0);
    check_val({tag, " puld"},  32'(ifdef.pulse),   32'd0);
    check_val({tag, " tstd"},  32'(ifdef.test),    32'd0);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned last_pulse;
    int unsigned n_pulse;
    int unsigned max_cnt;
    int unsigned double_hi;
    logic        prev_pulse;

    vec_cnt = 0;
    err_cnt = 0;
    rst     = 1'b0;

    // Reset hold for 10 cycles
    #1;
    check_all_clear("rst_t0");
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all_clear("rst_hold");
    end

    // Release and walk DIVISOR=4 and DIVISOR=2 for 12 edges
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_val("d4_cnt",  32'(if4.counter), 32'(k % 4));
      check_val("d4_pul",  32'(if4.pulse),   ((k % 4) == 0) ? 32'd1 : 32'd0);
      check_val("d4_tst",  32'(if4.test),    32'((k / 4) % 2));
      check_val("d2_cnt",  32'(if2.counter), 32'(k % 2));
      check_val("d2_pul",  32'(if2.pulse),   ((k % 2) == 0) ? 32'd1 : 32'd0);
      check_val("d2_tst",  32'(if2.test),    32'((k / 2) % 2));
      check_val("dd_cnt",  32'(ifdef.counter), 32'(k));
    end

    // Mid-period reset at counter == 2
    tick();
    tick();
    check_val("mid_pre_cnt", 32'(if4.counter), 32'd2);
    rst = 1'b0;
    #1;
    check_all_clear("mid_async");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all_clear("mid_hold");
    end
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_val("mid_cnt", 32'(if4.counter), 32'(k % 4));
      check_val("mid_pul", 32'(if4.pulse),   (k == 4) ? 32'd1 : 32'd0);
      check_val("mid_tst", 32'(if4.test),    (k == 4) ? 32'd1 : 32'd0);
    end

    // Default divisor: 11 pulses, 10 full intervals, from the same release
    cyc        = 4;
    last_pulse = 0;
    n_pulse    = 0;
    max_cnt    = 0;
    double_hi  = 0;
    prev_pulse = 1'b0;
    while ((n_pulse < 11) && (cyc < 868 * 13)) begin
      tick();
      cyc++;
      if (32'(ifdef.counter) > max_cnt) max_cnt = 32'(ifdef.counter);
      if (prev_pulse && ifdef.pulse) double_hi++;
      if (ifdef.pulse) begin
        if (n_pulse == 0) begin
          check_val("dd_first", cyc, 32'd868);
        end else begin
          check_val("dd_intvl", cyc - last_pulse, 32'd868);
        end
        check_val("dd_cnt0", 32'(ifdef.counter), 32'd0);
        check_val("dd_tst",  32'(ifdef.test), (n_pulse % 2 == 0) ? 32'd1 : 32'd0);
        last_pulse = cyc;
        n_pulse++;
      end
      prev_pulse = ifdef.pulse;
    end
    check_val("dd_npulse", n_pulse,   32'd11);
    check_val("dd_double", double_hi, 32'd0);
    check_val("dd_max",    max_cnt,   32'd867);

    // Reset asserted while DIVISOR=4 sits at terminal count: no pulse may follow
    for (int i = 0; i < 8 && if4.counter != 10'd3; i++) tick();
    check_val("tc_pre_cnt", 32'(if4.counter), 32'd3);
    rst = 1'b0;
    tick();
    check_val("tc_pul", 32'(if4.pulse),   32'd0);
    check_val("tc_cnt", 32'(if4.counter), 32'd0);
    check_val("tc_tst", 32'(if4.test),    32'd0);
    rst = 1'b1;
    tick();
    check_val("tc_rel_cnt", 32'(if4.counter), 32'd1);
    check_val("tc_rel_pul", 32'(if4.pulse),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
